// File: rtl/mov_issue_unit.sv
// Issue stage for the 16-bit MOV register: takes MOV_REG/MOV_IMM over valid/ready, drives
// the operand with a one-cycle capture strobe, then writes the returned value into an 8x16 rf.
module mov_issue_unit #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [15:0]   instr,
    output logic          instr_ready,
    output logic [DW-1:0] mov_src,
    output logic          mov_enable,
    input  logic [DW-1:0] mov_dest,
    output logic          done,
    output logic          err,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_waddr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic [AW-1:0] dbg_raddr,
    output logic [DW-1:0] dbg_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StWb} state_e;

    localparam logic [3:0] OpMovReg = 4'h1;
    localparam logic [3:0] OpMovImm = 4'h2;

    state_e        state;
    logic [AW-1:0] rd;
    logic [DW-1:0] rf [NREG];

    logic [3:0]    opcode;
    logic [AW-1:0] rs;
    logic [DW-1:0] imm_ext;

    assign opcode      = instr[15:12];
    assign rs          = instr[8:6];
    assign imm_ext     = {{(DW-9){instr[8]}}, instr[8:0]};
    assign instr_ready = (state == StIdle);
    assign dbg_rdata   = rf[dbg_raddr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            rd         <= '0;
            mov_src    <= '0;
            mov_enable <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // Debug write first so a same-edge write-back to the same entry overrides it.
            if (dbg_we) begin
                rf[dbg_waddr] <= dbg_wdata;
            end
            unique case (state)
                StIdle: begin
                    if (instr_valid) begin
                        rd <= instr[11:9];
                        if (opcode == OpMovReg) begin
                            mov_src    <= rf[rs];
                            mov_enable <= 1'b1;
                            state      <= StIssue;
                        end else if (opcode == OpMovImm) begin
                            mov_src    <= imm_ext;
                            mov_enable <= 1'b1;
                            state      <= StIssue;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    mov_enable <= 1'b0;
                    state      <= StWb;
                end
                StWb: begin
                    rf[rd] <= mov_dest;
                    done   <= 1'b1;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mov_issue_unit.sv
// Directed bench for mov_issue_unit: vector table for single instructions plus hand-written
// back-to-back and mid-instruction reset sequences. A small MOV register model feeds mov_dest.
module tb_mov_issue_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [15:0] mov_src;
    logic        mov_enable;
    logic [15:0] mov_dest;
    logic        done;
    logic        err;
    logic        dbg_we = 1'b0;
    logic [2:0]  dbg_waddr = '0;
    logic [15:0] dbg_wdata = '0;
    logic [2:0]  dbg_raddr = '0;
    logic [15:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mov_issue_unit dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .mov_src    (mov_src),
        .mov_enable (mov_enable),
        .mov_dest   (mov_dest),
        .done       (done),
        .err        (err),
        .dbg_we     (dbg_we),
        .dbg_waddr  (dbg_waddr),
        .dbg_wdata  (dbg_wdata),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    // Behavioural MOV destination register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mov_dest <= '0;
        else if (mov_enable) mov_dest <= mov_src;
    end

    typedef struct {
        logic [15:0] instr;
        logic        pre_we;
        logic [2:0]  pre_addr;
        logic [15:0] pre_data;
        logic        illegal;
        logic [15:0] exp_src;
        logic [2:0]  chk_addr;
        logic [15:0] exp_rf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rf(input logic [2:0] addr, input string name, input logic [15:0] exp);
        dbg_raddr = addr;
        #1;
        chk(name, dbg_rdata, exp);
    endtask

    initial begin
        vecs[0] = '{16'h260A, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h000A, 3'd3, 16'h000A};
        vecs[1] = '{16'h23F0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'hFFF0, 3'd1, 16'hFFF0};
        vecs[2] = '{16'h1540, 1'b1, 3'd5, 16'hF00C, 1'b0, 16'hF00C, 3'd2, 16'hF00C};
        vecs[3] = '{16'hF600, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000, 3'd3, 16'h000A};
        vecs[4] = '{16'h1E40, 1'b0, 3'd0, 16'h0000, 1'b0, 16'hFFF0, 3'd7, 16'hFFF0};
        vecs[5] = '{16'h20FF, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h00FF, 3'd0, 16'h00FF};

        // Reset state
        #12;
        chk("reset_ready", {15'd0, instr_ready}, 16'd1);
        chk("reset_src", mov_src, 16'h0000);
        chk("reset_en_done_err", {13'd0, mov_enable, done, err}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        read_rf(3'd3, "reset_rf3", 16'h0000);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (vecs[i].pre_we) begin
                dbg_we    = 1'b1;
                dbg_waddr = vecs[i].pre_addr;
                dbg_wdata = vecs[i].pre_data;
                @(negedge clk);
                dbg_we = 1'b0;
            end
            dbg_raddr   = vecs[i].chk_addr;
            instr       = vecs[i].instr;
            instr_valid = 1'b1;
            step();                               // E0
            instr_valid = 1'b0;
            if (vecs[i].illegal) begin
                chk($sformatf("v%0d_err", i), {15'd0, err}, 16'd1);
                chk($sformatf("v%0d_en", i), {15'd0, mov_enable}, 16'd0);
                chk($sformatf("v%0d_ready", i), {15'd0, instr_ready}, 16'd1);
                step();
                chk($sformatf("v%0d_err_pulse", i), {15'd0, err}, 16'd0);
                chk($sformatf("v%0d_ready2", i), {15'd0, instr_ready}, 16'd1);
                chk($sformatf("v%0d_rf", i), dbg_rdata, vecs[i].exp_rf);
            end else begin
                chk($sformatf("v%0d_en", i), {15'd0, mov_enable}, 16'd1);
                chk($sformatf("v%0d_src", i), mov_src, vecs[i].exp_src);
                chk($sformatf("v%0d_ready_lo1", i), {15'd0, instr_ready}, 16'd0);
                step();                           // E1
                chk($sformatf("v%0d_en_off", i), {15'd0, mov_enable}, 16'd0);
                chk($sformatf("v%0d_ready_lo2", i), {15'd0, instr_ready}, 16'd0);
                chk($sformatf("v%0d_no_done", i), {15'd0, done}, 16'd0);
                step();                           // E2
                chk($sformatf("v%0d_done", i), {15'd0, done}, 16'd1);
                chk($sformatf("v%0d_ready_hi", i), {15'd0, instr_ready}, 16'd1);
                chk($sformatf("v%0d_rf", i), dbg_rdata, vecs[i].exp_rf);
                chk($sformatf("v%0d_src_hold", i), mov_src, vecs[i].exp_src);
                step();
                chk($sformatf("v%0d_done_pulse", i), {15'd0, done}, 16'd0);
            end
        end

        // Back-to-back: valid held across two instructions
        @(negedge clk);
        instr       = 16'h2A11;
        instr_valid = 1'b1;
        step();                                   // E0
        chk("b2b_en_a", {15'd0, mov_enable}, 16'd1);
        chk("b2b_src_a", mov_src, 16'h0011);
        instr = 16'h2C22;
        step();                                   // E1
        chk("b2b_en_gap", {15'd0, mov_enable}, 16'd0);
        step();                                   // E2
        chk("b2b_done_a", {15'd0, done}, 16'd1);
        chk("b2b_ready", {15'd0, instr_ready}, 16'd1);
        step();                                   // E3: second accept
        instr_valid = 1'b0;
        chk("b2b_en_b", {15'd0, mov_enable}, 16'd1);
        chk("b2b_src_b", mov_src, 16'h0022);
        chk("b2b_done_gap", {15'd0, done}, 16'd0);
        step();
        step();                                   // E5
        chk("b2b_done_b", {15'd0, done}, 16'd1);
        step();
        chk("b2b_idle_en", {15'd0, mov_enable}, 16'd0);
        read_rf(3'd5, "b2b_rf5", 16'h0011);
        read_rf(3'd6, "b2b_rf6", 16'h0022);

        // Asynchronous reset during ISSUE
        @(negedge clk);
        instr       = 16'h2855;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("rst_pre_en", {15'd0, mov_enable}, 16'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_src", mov_src, 16'h0000);
        chk("rst_en_done_err", {13'd0, mov_enable, done, err}, 16'd0);
        chk("rst_ready", {15'd0, instr_ready}, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("rst_no_done%0d", c), {14'd0, done, mov_enable}, 16'd0);
        end
        chk("rst_ready_after", {15'd0, instr_ready}, 16'd1);
        read_rf(3'd4, "rst_rf4", 16'h0000);
        read_rf(3'd1, "rst_rf1", 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mov_issue_unit.md
Name: mov_issue_unit

Overview:
- Upstream issue stage for the 16-bit MOV destination register.
- Accepts MOV instructions over a valid/ready handshake and sources the operand from an internal 8x16 register file or from a sign-extended immediate.
- Drives src/mov_enable into the MOV register, then writes the returned dest value back into the register file.
- Provides a debug write port for preloading and a combinational debug read port.

Parameters:
- DW, 16, datapath width; must match the MOV register width.
- NREG, 8, register-file depth; register address width is 3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  instruction present.
- instr  in  16  instruction word.
- instr_ready  out  1  unit can accept an instruction.
- mov_src  out  16  operand to the MOV register.
- mov_enable  out  1  one-cycle capture strobe to the MOV register.
- mov_dest  in  16  MOV register output, sampled for write-back.
- done  out  1  one-cycle pulse when write-back completes.
- err  out  1  one-cycle pulse when an illegal opcode is accepted.
- dbg_we  in  1  debug register-file write enable.
- dbg_waddr  in  3  debug write address.
- dbg_wdata  in  16  debug write data.
- dbg_raddr  in  3  debug read address.
- dbg_rdata  out  16  combinational read of rf[dbg_raddr].

Behaviour:
- Instruction format:
  - [15:12] opcode: 4'h1 = MOV_REG, 4'h2 = MOV_IMM, any other value is illegal.
  - [11:9] rd (destination register).
  - MOV_REG: [8:6] rs; operand = rf[rs].
  - MOV_IMM: [8:0] imm9; operand = imm9 sign-extended to 16 bits.
- State machine: IDLE, ISSUE, WB. instr_ready = (state == IDLE) and is combinational from state.
- IDLE:
  - On instr_valid && instr_ready at edge E0, latch rd.
  - Legal opcode: register the operand into mov_src, set mov_enable = 1, go to ISSUE.
  - Illegal opcode: err = 1 for the following cycle, stay in IDLE, mov_enable stays 0.
- ISSUE: lasts exactly one cycle.
  - mov_enable = 1 and mov_src is stable throughout the cycle.
  - At edge E1: clear mov_enable, go to WB.
- WB: lasts exactly one cycle.
  - At edge E2: rf[rd] <= mov_dest, done = 1 for the following cycle, go to IDLE.
- Throughput and latency:
  - One instruction every 3 cycles.
  - done is asserted in the cycle after E2.
  - The next instruction can be accepted in that same cycle.
- The operand is read from rf at acceptance time (E0). The register-file read and mov_src are registered.
- Debug writes:
  - dbg_we is honoured in every state.
  - If a WB write and a dbg_we write target the same register at E2, the WB write wins.
  - A MOV_REG accepted at E0 while a debug write to rs occurs at the same edge reads the old value.
- dbg_rdata reflects rf contents after the most recent edge; there is no bypass.
- mov_src holds its last value after ISSUE; it is not cleared.
- Reset (rst = 0), asynchronous and any cycle, including mid-instruction:
  - state = IDLE; mov_src = 0, mov_enable = 0, done = 0, err = 0; all rf entries = 0.
  - An in-flight instruction is dropped with no write-back and no done pulse.
  - instr_ready = 1 after release.
- instr_valid deasserted while in IDLE: outputs hold, no pulses.
- Holding instr_valid high with the same instr causes a re-accept on each return to IDLE. The producer is responsible for dropping instr_valid.

Test Plan:
- Reset, then MOV_IMM rd=3, imm9=9'h00A (instr 16'h260A) -> mov_enable = 1 for exactly one cycle with mov_src = 16'h000A; done = 1 two cycles later; dbg_rdata at addr 3 = 16'h000A.
- MOV_IMM rd=1, imm9=9'h1F0 (instr 16'h23F0) -> mov_src = 16'hFFF0; rf[1] = 16'hFFF0 after done.
- Debug write rf[5] = 16'hF00C, then MOV_REG rd=2, rs=5 (instr 16'h1540) -> mov_src = 16'hF00C; rf[2] = 16'hF00C; instr_ready low for exactly 2 cycles.
- Illegal opcode 4'hF with instr_valid -> err pulses 1 cycle; mov_enable stays 0; no rf change; instr_ready never drops.
- Back-to-back: instr_valid held high with two queued instructions -> acceptances spaced exactly 3 cycles apart; done pulses 3 cycles apart.
- Assert rst = 0 during ISSUE of MOV_IMM rd=4 imm9=9'h055 -> all outputs 0 immediately; after release rf[4] = 0, no done pulse, instr_ready = 1.
